// File: rtl/nlfsr_keystream_gen.sv
// rtl/nlfsr_keystream_gen.sv - Fibonacci LFSR with nonlinear filter, packing keystream bits into bytes
// Optional zero-seed substitution enabled by defining NLFSR_KSG_LOCKUP_GUARD_EN
module nlfsr_keystream_gen #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'h8016,
  parameter logic [WIDTH-1:0] INIT   = 16'hACE1,
  parameter int unsigned      WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ready,
  output logic             ks_bit,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [WIDTH-1:0] state_o,
  output logic             lockup_o
);

  typedef enum logic {RUN = 1'b0, WARM = 1'b1} fsm_t;

  localparam logic [7:0] WARM_LOAD = 8'(WARMUP);

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_stepped;
  logic [WIDTH-1:0] seed_load;
  logic             feedback;
  logic [7:0]       warm_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       shreg;
  logic             handshake;
  logic             byte_done;
  logic             do_step;
  logic             collect;

  assign feedback     = ^(lfsr_q & TAPS);
  assign lfsr_stepped = {lfsr_q[WIDTH-2:0], feedback};
  assign ks_bit       = (lfsr_q[WIDTH-2] & lfsr_q[WIDTH-5]) ^ (lfsr_q[WIDTH-7] & lfsr_q[WIDTH-10])
                      ^ (lfsr_q[WIDTH-1] | lfsr_q[WIDTH-8]) ^ lfsr_q[2];
  assign state_o      = lfsr_q;
  assign seed_ready   = rst_n;
  assign handshake    = byte_valid & byte_ready;
  assign byte_done    = collect && (bit_cnt == 3'd7);

`ifdef NLFSR_KSG_LOCKUP_GUARD_EN
  assign seed_load = (seed_data == '0) ? INIT : seed_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockup_o <= 1'b0;
    end else if (seed_valid) begin
      lockup_o <= (seed_data == '0);
    end
  end
`else
  assign seed_load = seed_data;
  assign lockup_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= RUN;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // A completing byte stalls the whole generator while the previous byte is still unconsumed
  always_comb begin
    fsm_d   = fsm_q;
    do_step = 1'b0;
    collect = 1'b0;
    if (seed_valid) begin
      fsm_d = (WARM_LOAD != 8'd0) ? WARM : RUN;
    end else begin
      case (fsm_q)
        WARM: begin
          if (step_en) begin
            do_step = 1'b1;
            if (warm_cnt <= 8'd1) fsm_d = RUN;
          end
        end
        default: begin
          if (step_en && !(bit_cnt == 3'd7 && byte_valid && !byte_ready)) begin
            do_step = 1'b1;
            collect = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= INIT;
      warm_cnt   <= 8'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
    end else if (seed_valid) begin
      lfsr_q     <= seed_load;
      warm_cnt   <= WARM_LOAD;
      bit_cnt    <= 3'd0;
      byte_valid <= 1'b0;
    end else begin
      if (do_step) lfsr_q <= lfsr_stepped;
      if (do_step && fsm_q == WARM) warm_cnt <= warm_cnt - 8'd1;
      if (collect) begin
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shreg, ks_bit};
          byte_valid <= 1'b1;
          bit_cnt    <= 3'd0;
        end else begin
          shreg   <= {shreg[5:0], ks_bit};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (handshake && !byte_done) byte_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nlfsr_keystream_gen.sv
// tb/tb_nlfsr_keystream_gen.sv - directed self-checking bench for nlfsr_keystream_gen
module tb_nlfsr_keystream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_en, seed_valid, byte_ready;
  logic [15:0] seed_data;
  logic        seed_ready, ks_bit, byte_valid, lockup_o;
  logic [7:0]  byte_data;
  logic [15:0] state_o;

  logic        w_step_en, w_seed_valid, w_byte_ready;
  logic [15:0] w_seed_data;
  logic        w_seed_ready, w_ks_bit, w_byte_valid, w_lockup_o;
  logic [7:0]  w_byte_data;
  logic [15:0] w_state_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] m;
  logic [7:0]  b0, b1, first_byte;
  logic        kb;

  always #5 clk = ~clk;

  nlfsr_keystream_gen dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(seed_ready), .ks_bit(ks_bit),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .state_o(state_o), .lockup_o(lockup_o)
  );

  nlfsr_keystream_gen #(.WARMUP(4)) dut_warm (
    .clk(clk), .rst_n(rst_n), .step_en(w_step_en), .seed_valid(w_seed_valid),
    .seed_data(w_seed_data), .seed_ready(w_seed_ready), .ks_bit(w_ks_bit),
    .byte_data(w_byte_data), .byte_valid(w_byte_valid), .byte_ready(w_byte_ready),
    .state_o(w_state_o), .lockup_o(w_lockup_o)
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[4] ^ s[2] ^ s[1]};
  endfunction

  function automatic logic m_ks(input logic [15:0] s);
    return (s[14] & s[11]) ^ (s[9] & s[6]) ^ (s[15] | s[8]) ^ s[2];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; step_en = 1'b0; seed_valid = 1'b0; seed_data = '0; byte_ready = 1'b0;
    w_step_en = 1'b0; w_seed_valid = 1'b0; w_seed_data = '0; w_byte_ready = 1'b0;
    cyc(); cyc();
    check("rst_seed_ready", 64'(seed_ready), 64'(0));
    check("rst_state", 64'(state_o), 64'(16'hACE1));
    check("rst_valid", 64'(byte_valid), 64'(0));
    rst_n = 1'b1;
    repeat (10) cyc();
    check("idle_state", 64'(state_o), 64'(16'hACE1));
    check("idle_ks", 64'(ks_bit), 64'(1));
    check("idle_valid", 64'(byte_valid), 64'(0));
    check("idle_seed_ready", 64'(seed_ready), 64'(1));
    check("idle_lockup", 64'(lockup_o), 64'(0));
    check("idle_byte", 64'(byte_data), 64'(0));

    step_en = 1'b1; cyc(); step_en = 1'b0;
    check("step1_state", 64'(state_o), 64'(16'h59C3));
    check("step1_ks", 64'(ks_bit), 64'(0));

    // 16 steps with no consumer: first byte after 8, stall on the 16th
    do_reset();
    m = 16'hACE1; b0 = '0; b1 = '0;
    step_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i < 15) begin
        kb = m_ks(m);
        if (i < 8) b0 = {b0[6:0], kb};
        else       b1 = {b1[6:0], kb};
        m = m_step(m);
      end
      if (i == 6) check("valid_before_8", 64'(byte_valid), 64'(0));
      if (i == 7) begin
        check("valid_after_8", 64'(byte_valid), 64'(1));
        check("byte0", 64'(byte_data), 64'(b0));
      end
    end
    first_byte = b0;
    check("stall_state", 64'(state_o), 64'(m));
    check("stall_valid", 64'(byte_valid), 64'(1));
    repeat (3) cyc();
    check("stall_hold_state", 64'(state_o), 64'(m));
    check("stall_hold_byte", 64'(byte_data), 64'(b0));
    byte_ready = 1'b1;
    b1 = {b1[6:0], m_ks(m)};
    m = m_step(m);
    cyc();
    byte_ready = 1'b0; step_en = 1'b0;
    check("hs_fill_valid", 64'(byte_valid), 64'(1));
    check("byte1", 64'(byte_data), 64'(b1));
    check("hs_fill_state", 64'(state_o), 64'(m));
    byte_ready = 1'b1; cyc(); byte_ready = 1'b0;
    check("hs_drain_valid", 64'(byte_valid), 64'(0));

    // seed wins over a simultaneous step
    seed_valid = 1'b1; seed_data = 16'h1234; step_en = 1'b1;
    cyc();
    seed_valid = 1'b0; step_en = 1'b0;
    check("seed_prio_state", 64'(state_o), 64'(16'h1234));
    check("seed_prio_valid", 64'(byte_valid), 64'(0));

    seed_valid = 1'b1; seed_data = 16'h0000; cyc(); seed_valid = 1'b0;
`ifdef NLFSR_KSG_LOCKUP_GUARD_EN
    check("zero_seed_state", 64'(state_o), 64'(16'hACE1));
    check("zero_seed_lockup", 64'(lockup_o), 64'(1));
    seed_valid = 1'b1; seed_data = 16'h1234; cyc(); seed_valid = 1'b0;
    check("nonzero_clears_lockup", 64'(lockup_o), 64'(0));
`else
    check("zero_seed_state", 64'(state_o), 64'(0));
    step_en = 1'b1; repeat (20) cyc(); step_en = 1'b0;
    check("zero_20_state", 64'(state_o), 64'(0));
    check("zero_20_ks", 64'(ks_bit), 64'(0));
    check("zero_lockup", 64'(lockup_o), 64'(0));
`endif

    // reset after 5 collected bits discards them
    do_reset();
    step_en = 1'b1; repeat (5) cyc(); step_en = 1'b0;
    rst_n = 1'b0; #2;
    check("midrst_seed_ready", 64'(seed_ready), 64'(0));
    check("midrst_state", 64'(state_o), 64'(16'hACE1));
    rst_n = 1'b1;
    cyc();
    check("midrst_valid", 64'(byte_valid), 64'(0));
    step_en = 1'b1;
    repeat (7) cyc();
    check("midrst_valid_7", 64'(byte_valid), 64'(0));
    cyc();
    step_en = 1'b0;
    check("midrst_valid_8", 64'(byte_valid), 64'(1));
    check("midrst_byte", 64'(byte_data), 64'(first_byte));

    // WARMUP=4: first four steps discarded, byte from steps 5..12
    w_seed_valid = 1'b1; w_seed_data = 16'h1234; cyc(); w_seed_valid = 1'b0;
    check("warm_seed_state", 64'(w_state_o), 64'(16'h1234));
    m = 16'h1234; b0 = '0;
    w_step_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k >= 5) b0 = {b0[6:0], m_ks(m)};
      m = m_step(m);
      if (k == 11) check("warm_valid_11", 64'(w_byte_valid), 64'(0));
    end
    w_step_en = 1'b0;
    check("warm_valid_12", 64'(w_byte_valid), 64'(1));
    check("warm_byte", 64'(w_byte_data), 64'(b0));
    check("warm_state", 64'(w_state_o), 64'(m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nlfsr_keystream_gen.md
NLFSR_KEYSTREAM_GEN -- requirements
Module: nlfsr_keystream_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, LFSR length in bits (legal range 16..64).
REQ-002 SHALL have parameter TAPS, default 16'h8016, WIDTH-bit feedback tap mask.
REQ-003 SHALL have parameter INIT, default 16'hACE1, WIDTH-bit reset and substitute seed.
REQ-004 SHALL have parameter WARMUP, default 0, number of steps discarded after each seed load (range 0..255).
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port step_en  in  1  advance request for one LFSR step this cycle.
REQ-008 SHALL have port seed_valid  in  1  seed load request.
REQ-009 SHALL have port seed_data  in  WIDTH  seed value.
REQ-010 SHALL have port seed_ready  out  1  seed accept indication, constant 1 outside reset.
REQ-011 SHALL have port ks_bit  out  1  combinational filter output of the current state.
REQ-012 SHALL have port byte_data  out  8  assembled keystream byte.
REQ-013 SHALL have port byte_valid  out  1  byte_data holds an unconsumed byte.
REQ-014 SHALL have port byte_ready  in  1  consumer accept; handshake = byte_valid & byte_ready.
REQ-015 SHALL have port state_o  out  WIDTH  current LFSR state.
REQ-016 SHALL have port lockup_o  out  1  sticky zero-seed-substitution flag.

Function
REQ-017 SHALL compute feedback = XOR of s[i] over all i where TAPS[i]=1; a step SHALL load s <= {s[WIDTH-2:0], feedback}.
REQ-018 SHALL compute ks_bit = (s[W-2]&s[W-5]) ^ (s[W-7]&s[W-10]) ^ (s[W-1]|s[W-8]) ^ s[2], W=WIDTH.
REQ-019 SHALL implement FSM states WARM and RUN; reset enters RUN.
REQ-020 SHALL, on seed_valid, load seed_data, clear bit counter and byte_valid, set warm counter to WARMUP, and enter WARM if WARMUP>0 else RUN.
REQ-021 SHALL give seed acceptance priority over step_en in the same cycle; no step occurs that cycle.
REQ-022 SHALL, in WARM on step_en, step the LFSR and decrement the warm counter, collecting no bits; counter reaching 0 SHALL enter RUN on the following cycle.
REQ-023 SHALL, in RUN on step_en, step the LFSR and shift the pre-step ks_bit into the assembler, MSB first.
REQ-024 SHALL, on the 8th collected bit, transfer the byte to byte_data and assert byte_valid the next cycle; bit counter wraps to 0.
REQ-025 SHALL stall (no LFSR step, no bit collected) when the 8th bit would complete while byte_valid=1 and no handshake occurs that cycle.
REQ-026 SHALL, on handshake coinciding with 8th-bit completion, load the new byte and keep byte_valid=1.
REQ-027 SHALL, on handshake without completion, deassert byte_valid the next cycle.
REQ-028 SHALL keep byte_data stable while byte_valid=1 and no handshake occurs.

Reset
REQ-029 SHALL, on rst_n low, set state to INIT, FSM to RUN, warm and bit counters to 0, byte_data 8'h00, byte_valid 0, lockup_o 0.
REQ-030 SHALL hold seed_ready 0 during reset and 1 otherwise; reset mid-byte SHALL discard partial bits.

Configuration
REQ-031 SHALL honour macro NLFSR_KSG_LOCKUP_GUARD_EN.
REQ-032 SHALL, with NLFSR_KSG_LOCKUP_GUARD_EN defined, replace an all-zero seed by INIT and set lockup_o; any nonzero seed load SHALL clear lockup_o.
REQ-033 SHALL, without NLFSR_KSG_LOCKUP_GUARD_EN, load an all-zero seed verbatim (generator stays zero) and tie lockup_o to 0.

Verification
REQ-034 SHALL cover: reset release, step_en=0 -> state_o=16'hACE1, ks_bit=1, byte_valid=0, seed_ready=1, held indefinitely.
REQ-035 SHALL cover: one step_en cycle from reset -> state_o=16'h59C3, ks_bit=0.
REQ-036 SHALL cover: 16 steps with byte_ready=0 -> byte_valid rises after 8th step with model byte; 16th step stalls, state_o frozen until one byte_ready cycle.
REQ-037 SHALL cover: seed 16'h0000 -> with guard, state_o=16'hACE1 and lockup_o=1; without guard, state_o=0 and ks_bit=0 after 20 steps.
REQ-038 SHALL cover: WARMUP=4, seed 16'h1234, continuous step_en -> byte_valid first rises after 12th step, byte equal to model bits 5..12.
REQ-039 SHALL cover: rst_n pulsed after 5 collected bits -> state_o=16'hACE1, byte_valid=0, next byte needs 8 full steps.
